// File: rtl/debounce_edge_detect_pkg.sv
// Shared types for the debounce/edge-detect conditioning stage: FSM state
// encoding and a sizing helper for the debounce counter.
package debounce_edge_detect_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    // Smallest counter width that can hold DEBOUNCE_CYCLES-1 (never below 1 bit).
    function automatic int min_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// Metastability synchronizer: din ripples through SYNC_STAGES flops; the last
// stage is the only synchronous view of the raw input.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s
);

    logic [SYNC_STAGES-1:0] stage_r;

    // Shift register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], din};
        end
    end

    assign s = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounce FSM with tick-gated stability counter and registered rise/fall
// pulses, fed by a synchronizer chain on the raw input.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    output logic db_q,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             db_q_r, db_nxt_s;
    logic             rise_r, rise_nxt_s;
    logic             fall_r, fall_nxt_s;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .s    (s)
    );

    // Next-state logic; an s reversal is checked before the terminal tick so aborts win.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        db_nxt_s    = db_q_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            STABLE_LO: begin
                if (s) begin
                    state_nxt_s = WAIT_HI;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = STABLE_LO;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = '0;
                end else if (tick && (cnt_r == CNT_LAST)) begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = '0;
                    db_nxt_s    = 1'b1;
                    rise_nxt_s  = 1'b1;
                end else if (tick) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_nxt_s = WAIT_LO;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = STABLE_HI;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = '0;
                end else if (tick && (cnt_r == CNT_LAST)) begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = '0;
                    db_nxt_s    = 1'b0;
                    fall_nxt_s  = 1'b1;
                end else if (tick) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = STABLE_LO;
                cnt_nxt_s   = '0;
                db_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= STABLE_LO;
            cnt_r   <= '0;
            db_q_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            db_q_r  <= db_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    assign db_q = db_q_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench: a run-length reference model of the debouncer is
// compared with the DUT after every clock, plus literal checkpoints.
module tb_debounce_edge_detect;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic tick = 1'b1;
    logic db_q, rise, fall;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [SYNC-1:0] hist = '0;
    logic m_db = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    bit   in_run = 1'b0;
    int   run_ticks = 0;

    debounce_edge_detect #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .tick (tick),
        .db_q (db_q),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // The output flips once s has disagreed with it for a run of edges that
    // contains DEB ticks after the run's first edge; any agreement ends the run.
    task automatic model_edge();
        logic s_old;
        if (!rst_n) begin
            hist = '0; m_db = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            in_run = 1'b0; run_ticks = 0;
        end else begin
            s_old = hist[SYNC-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s_old != m_db) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    run_ticks = 0;
                end else if (tick) begin
                    run_ticks++;
                    if (run_ticks == DEB) begin
                        m_db = s_old;
                        m_rise = s_old;
                        m_fall = ~s_old;
                        in_run = 1'b0;
                    end
                end
            end else begin
                in_run = 1'b0;
            end
            hist = {hist[SYNC-2:0], din};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("db_q", db_q, m_db);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("rise_fall_excl", rise & fall, 1'b0);
    endtask

    task automatic pin(input string name, input logic dut_v, input logic mod_v, input logic exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mod_v, exp);
    endtask

    initial begin
        int hold;

        // reset with din high: outputs stay low, then a fresh rise after 7 edges
        din = 1'b1; tick = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            pin("rst_db", db_q, m_db, 1'b0);
            pin("rst_rise", rise, m_rise, 1'b0);
            pin("rst_fall", fall, m_fall, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) begin
                pin("rel_db6", db_q, m_db, 1'b0);
                pin("rel_rise6", rise, m_rise, 1'b0);
            end
            if (i == 7) begin
                pin("rel_db7", db_q, m_db, 1'b1);
                pin("rel_rise7", rise, m_rise, 1'b1);
            end
            if (i == 8) begin
                pin("rel_db8", db_q, m_db, 1'b1);
                pin("rel_rise8", rise, m_rise, 1'b0);
            end
        end

        // clean fall: din low before E0, fall visible after E6
        din = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            step();
            if (i == 5) pin("cf_db5", db_q, m_db, 1'b1);
            if (i == 6) begin
                pin("cf_db6", db_q, m_db, 1'b0);
                pin("cf_fall6", fall, m_fall, 1'b1);
                pin("cf_rise6", rise, m_rise, 1'b0);
            end
            if (i == 7) pin("cf_fall7", fall, m_fall, 1'b0);
        end

        // clean rise: din high before E0, rise visible after E6
        din = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step();
            if (i == 5) pin("cr_db5", db_q, m_db, 1'b0);
            if (i == 6) begin
                pin("cr_db6", db_q, m_db, 1'b1);
                pin("cr_rise6", rise, m_rise, 1'b1);
            end
            if (i == 7) pin("cr_rise7", rise, m_rise, 1'b0);
        end

        din = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // bounce: 3 high, 2 low, 3 high, then low -> never qualifies
        for (int i = 0; i < 3; i++) begin din = 1'b1; step(); end
        for (int i = 0; i < 2; i++) begin din = 1'b0; step(); end
        for (int i = 0; i < 3; i++) begin din = 1'b1; step(); end
        din = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            pin("bounce_rise", rise, m_rise, 1'b0);
        end
        pin("bounce_db", db_q, m_db, 1'b0);

        // tick gating: one tick every third cycle
        din = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick = ((i % 3) == 0) ? 1'b1 : 1'b0;
            step();
            if (i == 8) pin("tg_db_early", db_q, m_db, 1'b0);
        end
        pin("tg_db_hi", db_q, m_db, 1'b1);
        din = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick = ((i % 3) == 1) ? 1'b1 : 1'b0;
            step();
        end
        pin("tg_db_lo", db_q, m_db, 1'b0);

        // mid-count reset: reset at E4 wipes progress, rise 7 edges after release
        tick = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        pin("mc_db", db_q, m_db, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) pin("mc_rise6", rise, m_rise, 1'b0);
            if (i == 7) pin("mc_rise7", rise, m_rise, 1'b1);
        end

        // randomized stimulus with occasional resets
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                din = $urandom_range(0, 1) == 1;
                hold = $urandom_range(1, 9);
            end
            hold--;
            tick = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
